bcd_conv_sched: RTL and testbench

Round-robin scheduler that shares one binary-to-BCD converter (the `BinaryToDec` datapath) among NREQ requesters, e.g. several on-screen counters feeding one 7-segment/OSD display path.
- The converter has no handshake and a fixed pipeline latency. This block therefore owns the converter input: it holds each value stable for CONV_LAT cycles, samples the converter output and returns the BCD result to the granted requester with a one-cycle done pulse.
- It sits between the requesting counters and the single converter instance.

---
 rtl/bcd_conv_sched.sv | 140 ++++++++++++++
 tb/tb_bcd_conv_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: shares one fixed-latency binary-to-BCD converter among NREQ
// requesters. A granted requester's value is latched onto conv_in and held for
// CONV_LAT cycles. The converter output is then captured into bcd_out, and the
// served requester gets a one-cycle done pulse.
//
// Configuration macro: BCD_SCHED_PRIO_EN
//   undefined (default) : round-robin arbitration starting at ptr
//   defined             : fixed priority, lowest set req index wins (ptr held at 0)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   req       per-requester request level, held until the matching done
//   data_in   requester i's binary value in bits [16i+15:16i]
//   conv_in   converter input, held stable during a conversion
//   conv_out  converter BCD output
//   bcd_out   captured BCD result, valid while done is high
//   done      one-hot, one-cycle pulse to the served requester
//   grant_id  index of the requester in service or last served
//   busy      high while a conversion is in flight (WAIT and DONE)
module bcd_conv_sched #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned IDW      = 2,
  parameter int unsigned CONV_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data_in,
  output logic [15:0]          conv_in,
  input  logic [15:0]          conv_out,
  output logic [15:0]          bcd_out,
  output logic [NREQ-1:0]      done,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

  localparam int unsigned DW   = 16;
  localparam int unsigned CNTW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [CNTW-1:0] cnt;

  logic [2*NREQ-1:0] rot_c;
  logic [IDW:0]      sum_c;
  logic [IDW-1:0]    winner_c;
  logic              found_c;
  logic [DW-1:0]     sel_data_c;
  logic [IDW-1:0]    next_ptr_c;

  // Winner search: rotate req so bit 0 is ptr, take the first set bit,
  // then map the rotated position back to a requester index.
  always_comb begin
    rot_c    = {req, req} >> ptr;
    sum_c    = '0;
    winner_c = '0;
    found_c  = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!found_c && rot_c[j]) begin
        found_c = 1'b1;
        sum_c   = {1'b0, ptr} + (IDW+1)'(j);
        if (sum_c >= (IDW+1)'(NREQ)) begin
          sum_c = sum_c - (IDW+1)'(NREQ);
        end
        winner_c = sum_c[IDW-1:0];
      end
    end
  end

  // Data slice of the winner.
  always_comb begin
    sel_data_c = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (winner_c == IDW'(k)) begin
        sel_data_c = data_in[k*DW +: DW];
      end
    end
  end

  // Pointer to resume the search after the requester just served.
  always_comb begin
`ifdef BCD_SCHED_PRIO_EN
    next_ptr_c = '0;
`else
    next_ptr_c = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
`endif
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      conv_in  <= '0;
      bcd_out  <= '0;
      done     <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found_c) begin
            conv_in  <= sel_data_c;
            grant_id <= winner_c;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + CNTW'(1);
          // conv_in has now been held CONV_LAT cycles; conv_out is valid.
          if (cnt == CNTW'(CONV_LAT-1)) begin
            bcd_out <= conv_out;
            done    <= NREQ'(1) << grant_id;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= '0;
          busy  <= 1'b0;
          ptr   <= next_ptr_c;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: directed stimulus for bcd_conv_sched with a scoreboard.
// Expected done events (one-hot, BCD value, grant index, cycle) are queued when
// stimulus is issued. A negedge monitor pops and compares on every done pulse.
// The converter model returns ~conv_in, valid CONV_LAT cycles after conv_in changes.
module tb_bcd_conv_sched;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned IDW      = 2;
  localparam int unsigned CONV_LAT = 4;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  data_in;
  logic [15:0]         conv_in;
  logic [15:0]         conv_out;
  logic [15:0]         bcd_out;
  logic [NREQ-1:0]     done;
  logic [IDW-1:0]      grant_id;
  logic                busy;

  bcd_conv_sched #(.NREQ(NREQ), .IDW(IDW), .CONV_LAT(CONV_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .conv_in  (conv_in),
    .conv_out (conv_out),
    .bcd_out  (bcd_out),
    .done     (done),
    .grant_id (grant_id),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter model: inversion plus a register chain, so the DUT's sample
  // edge, CONV_LAT edges after conv_in changed, sees ~conv_in.
  logic [15:0] pipe [0:CONV_LAT-2];
  always @(posedge clk) begin
    pipe[0] <= ~conv_in;
    for (int p = 1; p < int'(CONV_LAT) - 1; p++) pipe[p] <= pipe[p-1];
  end
  assign conv_out = pipe[CONV_LAT-2];

  typedef struct {
    logic [NREQ-1:0] done;
    logic [15:0]     bcd;
    logic [IDW-1:0]  gid;
    int              at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at cycle %0d", name, act, want, cyc);
    end
  endtask

  task automatic expect_done(input int idx, input logic [15:0] val, input int at);
    exp_t e;
    e.done = NREQ'(1) << idx;
    e.bcd  = ~val;
    e.gid  = IDW'(idx);
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_data(input int idx, input logic [15:0] val);
    data_in[16*idx +: 16] = val;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_conv_in"},  32'(conv_in),  32'h0);
    check({tag, "_bcd_out"},  32'(bcd_out),  32'h0);
    check({tag, "_done"},     32'(done),     32'h0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'h0);
    check({tag, "_busy"},     32'(busy),     32'h0);
  endtask

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got %b want none at cycle %0d", done, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("done",       32'(done),     32'(mon_e.done));
        check("bcd_out",    32'(bcd_out),  32'(mon_e.bcd));
        check("grant_id",   32'(grant_id), 32'(mon_e.gid));
        check("done_cycle", 32'(cyc),      32'(mon_e.at));
      end
    end
  end

  logic [15:0] fv [0:3];

  initial begin
    rst     = 1'b0;
    req     = '0;
    data_in = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    // Single request from requester 2.
    set_data(2, 16'h1234);
    req  = 4'b0100;
    base = cyc;
    expect_done(2, 16'h1234, base + 5);
    wait_to(base + 1);
    check("s1_conv_in", 32'(conv_in), 32'h1234);
    check("s1_busy_c1", 32'(busy), 32'h1);
    wait_to(base + 5);
    check("s1_busy_c5", 32'(busy), 32'h1);
    req = '0;
    wait_to(base + 6);
    check("s1_busy_c6", 32'(busy), 32'h0);
    check("s1_drain", 32'(exp_q.size()), 32'h0);

    // Two simultaneous requests from reset: 0 first, then 1.
    do_reset();
    set_data(0, 16'h0001);
    set_data(1, 16'h0002);
    req  = 4'b0011;
    base = cyc;
    expect_done(0, 16'h0001, base + 5);
    expect_done(1, 16'h0002, base + 11);
    wait_to(base + 7);
    check("s2_conv_in_c7", 32'(conv_in), 32'h0002);
    check("s2_grant_c7", 32'(grant_id), 32'h1);
    wait_to(base + 11);
    req = '0;
    wait_to(base + 13);
    check("s2_drain", 32'(exp_q.size()), 32'h0);

    // All four requesting for 30 cycles.
    do_reset();
    fv[0] = 16'h0123; fv[1] = 16'h4567; fv[2] = 16'h89AB; fv[3] = 16'hCDEF;
    for (int i = 0; i < 4; i++) set_data(i, fv[i]);
    req  = 4'b1111;
    base = cyc;
    for (int k = 0; k < 5; k++) begin
`ifdef BCD_SCHED_PRIO_EN
      expect_done(0, fv[0], base + 5 + 6*k);
`else
      expect_done(k % 4, fv[k % 4], base + 5 + 6*k);
`endif
    end
    wait_to(base + 29);
    req = '0;
    wait_to(base + 31);
    check("s3_drain", 32'(exp_q.size()), 32'h0);

    // Requester 0 drops req mid-service and changes its data.
    do_reset();
    set_data(0, 16'h00AA);
    req  = 4'b0001;
    base = cyc;
    expect_done(0, 16'h00AA, base + 5);
    wait_to(base + 2);
    req = '0;
    set_data(0, 16'hFFFF);
    wait_to(base + 12);
    check("s4_busy_idle", 32'(busy), 32'h0);
    check("s4_conv_in_kept", 32'(conv_in), 32'h00AA);
    check("s4_drain", 32'(exp_q.size()), 32'h0);

    // Reset during WAIT, then the held request is served again.
    do_reset();
    set_data(3, 16'h5678);
    req  = 4'b1000;
    base = cyc;
    wait_to(base + 3);
    rst = 1'b0;
    #1;
    check_zero_outputs("s5_rst");
    @(negedge clk);
    rst  = 1'b1;
    base = cyc;
    expect_done(3, 16'h5678, base + 5);
    wait_to(base + 1);
    check("s5_conv_in", 32'(conv_in), 32'h5678);
    wait_to(base + 5);
    req = '0;
    wait_to(base + 7);
    check("s5_drain", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
